// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan decoder:
// active-low segment patterns (bit6=a .. bit0=g), digit count and FSM state type.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    // Number of active (low) digit enables.
    function automatic logic [2:0] count_low(input logic [3:0] an_v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            cnt = cnt + {2'b00, ~an_v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low seven-segment pattern to BCD decoder; unknown
// patterns yield 4'hF with o_invalid set.
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_invalid
);

    // Pattern lookup
    always_comb begin
        o_value   = 4'hF;
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0:   o_value = 4'd0;
            SEG_1:   o_value = 4'd1;
            SEG_2:   o_value = 4'd2;
            SEG_3:   o_value = 4'd3;
            SEG_4:   o_value = 4'd4;
            SEG_5:   o_value = 4'd5;
            SEG_6:   o_value = 4'd6;
            SEG_7:   o_value = 4'd7;
            SEG_8:   o_value = 4'd8;
            SEG_9:   o_value = 4'd9;
            default: begin
                o_value   = 4'hF;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a four-digit MM:SS frame from a scanned seven-segment display bus.
// Optional time-format check enabled by defining SEG_SCAN_RANGE_CHECK_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [3:0]  an,
    input  logic [6:0]  a_to_g,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        range_err
);

    localparam int              CW       = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CNT);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    state_t        r_state;
    logic [10:0]   r_prev;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_slots;
    logic [3:0]    r_seen;
    logic          r_acc;
    logic [15:0]   r_digits;
    logic          r_fv;
    logic          r_seg_err;
    logic          r_an_err;
    logic          r_range_err;

    logic [3:0]    w_value;
    logic          w_invalid;
    logic          w_changed;
    logic [CW-1:0] w_cnt_next;
    logic          w_capture;
    logic [2:0]    w_low_cnt;
    logic          w_frame_done;
    logic [3:0]    w_seen_base;
    logic          w_acc_base;
    logic          w_range_bad;

    seg7_pattern_decode u_decode (
        .i_pattern (a_to_g),
        .o_value   (w_value),
        .o_invalid (w_invalid)
    );

    assign w_changed    = ({an, a_to_g} != r_prev);
    assign w_low_cnt    = count_low(an);
    assign w_frame_done = (r_seen == 4'hF);

    // Saturating stability counter and capture strobe; a change from HOLD can
    // capture directly only when a single stable cycle suffices.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_changed) begin
            w_cnt_next = CNT_ONE;
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
        w_capture   = (w_cnt_next == CNT_MAX) && ((r_state == SETTLE) || w_changed);
        w_seen_base = w_frame_done ? 4'h0 : r_seen;
        w_acc_base  = w_frame_done ? 1'b0 : r_acc;
    end

`ifdef SEG_SCAN_RANGE_CHECK_EN
    // Tens digits of minutes and seconds must be 0..5; no digit may be invalid.
    always_comb begin
        w_range_bad = (r_slots[7:4] > 4'd5) || (r_slots[15:12] > 4'd5);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_slots[4*k +: 4] == 4'hF) begin
                w_range_bad = 1'b1;
            end else begin
                w_range_bad = w_range_bad;
            end
        end
    end
`else
    assign w_range_bad = 1'b0;
`endif

    // FSM, slot capture and frame publication
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= SETTLE;
            r_prev      <= 11'd0;
            r_cnt       <= '0;
            r_slots     <= 16'h0000;
            r_seen      <= 4'h0;
            r_acc       <= 1'b0;
            r_digits    <= 16'h0000;
            r_fv        <= 1'b0;
            r_seg_err   <= 1'b0;
            r_an_err    <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_prev <= {an, a_to_g};
            r_cnt  <= w_cnt_next;

            case (r_state)
                SETTLE:  r_state <= w_capture ? HOLD : SETTLE;
                HOLD:    r_state <= (w_changed && !w_capture) ? SETTLE : HOLD;
                default: r_state <= SETTLE;
            endcase

            if (w_capture && (w_low_cnt == 3'd1)) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (!an[k]) begin
                        r_slots[4*k +: 4] <= w_value;
                    end
                end
                r_seen <= w_seen_base | ~an;
                r_acc  <= w_acc_base | w_invalid;
            end else begin
                r_seen <= w_seen_base;
                r_acc  <= w_acc_base;
            end

            if (w_capture && (w_low_cnt >= 3'd2)) begin
                r_an_err <= 1'b1;
            end

            r_fv <= w_frame_done;
            if (w_frame_done) begin
                r_digits    <= r_slots;
                r_seg_err   <= r_acc;
                r_range_err <= w_range_bad;
            end
        end
    end

    assign digits      = r_digits;
    assign frame_valid = r_fv;
    assign seg_err     = r_seg_err;
    assign an_err      = r_an_err;
    assign range_err   = r_range_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (STABLE_CNT=4); expected
// range_err follows SEG_SCAN_RANGE_CHECK_EN.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
`ifdef SEG_SCAN_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    localparam logic [6:0] P0 = 7'b0000001;
    localparam logic [6:0] P1 = 7'b1001111;
    localparam logic [6:0] P2 = 7'b0010010;
    localparam logic [6:0] P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100;
    localparam logic [6:0] P5 = 7'b0100100;
    localparam logic [6:0] P6 = 7'b0100000;
    localparam logic [6:0] P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0000100;
    localparam logic [6:0] PX = 7'b1111111;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  a_to_g = 7'b1111111;
    logic [15:0] digits;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;
    logic        range_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fv_count = 0;
    int fv_cyc   = -1;
    int t_start  = 0;

    seg_scan_decoder #(.STABLE_CNT(STABLE)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .an          (an),
        .a_to_g      (a_to_g),
        .digits      (digits),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .an_err      (an_err),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_count <= fv_count + 1;
            fv_cyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: apply inputs, then hold them for n cycles.
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an     = a;
        a_to_g = s;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_digits", {16'h0, digits}, 32'h0);
        check("rst_flags", {28'h0, frame_valid, seg_err, an_err, range_err}, 32'h0);
        clr_n = 1'b1;

        // Frame 1: 3,5,0,2 -> 16'h2053, latency STABLE_CNT+1 on last digit
        drive(4'b1110, P3, 8);
        drive(4'b1101, P5, 8);
        drive(4'b1011, P0, 8);
        t_start = cyc;
        drive(4'b0111, P2, 8);
        check("f1_count", fv_count, 1);
        check("f1_latency", fv_cyc, t_start + 1 + STABLE);
        check("f1_digits", {16'h0, digits}, 32'h2053);
        check("f1_seg_err", {31'h0, seg_err}, 32'h0);
        check("f1_range", {31'h0, range_err}, 32'h0);
        check("f1_fv_low", {31'h0, frame_valid}, 32'h0);

        // Frame 2: too-short digit ignored, blank ignored, invalid pattern on an[2]
        drive(4'b1110, P7, 3);
        drive(4'b1111, PX, 8);
        drive(4'b1101, P4, 8);
        drive(4'b1011, PX, 8);
        drive(4'b0111, P1, 8);
        check("f2_no_frame", fv_count, 1);
        check("f2_hold_digits", {16'h0, digits}, 32'h2053);
        drive(4'b1110, P9, 8);
        check("f2_count", fv_count, 2);
        check("f2_digits", {16'h0, digits}, 32'h1F49);
        check("f2_seg_err", {31'h0, seg_err}, 32'h1);
        check("f2_range", {31'h0, range_err}, {31'h0, RC});
        drive(4'b1111, PX, 6);
        check("f2_stable", {16'h0, digits}, 32'h1F49);

        // Frame 3: 16'h7000 fails the minutes-tens check
        drive(4'b1110, P0, 8);
        drive(4'b1101, P0, 8);
        drive(4'b1011, P0, 8);
        drive(4'b0111, P7, 8);
        check("f3_count", fv_count, 3);
        check("f3_digits", {16'h0, digits}, 32'h7000);
        check("f3_seg_err", {31'h0, seg_err}, 32'h0);
        check("f3_range", {31'h0, range_err}, {31'h0, RC});

        // Two enables low: sticky an_err, no slot write
        drive(4'b1100, P8, 8);
        check("an_err_set", {31'h0, an_err}, 32'h1);
        check("an_err_nofv", fv_count, 3);
        drive(4'b1110, P1, 8);
        drive(4'b1101, P2, 8);
        drive(4'b1011, P3, 8);
        drive(4'b0111, P4, 8);
        check("f4_count", fv_count, 4);
        check("f4_digits", {16'h0, digits}, 32'h4321);
        check("f4_an_err", {31'h0, an_err}, 32'h1);
        check("f4_range", {31'h0, range_err}, 32'h0);

        // Reset after three captured digits discards the partial frame
        drive(4'b1110, P5, 8);
        drive(4'b1101, P6, 8);
        drive(4'b1011, P8, 8);
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_digits", {16'h0, digits}, 32'h0);
        check("mid_rst_flags", {28'h0, frame_valid, seg_err, an_err, range_err}, 32'h0);
        clr_n = 1'b1;
        drive(4'b0111, P9, 8);
        check("post_rst_nofv", fv_count, 4);
        drive(4'b1110, P5, 8);
        drive(4'b1101, P6, 8);
        check("post_rst_partial", fv_count, 4);
        drive(4'b1011, P8, 8);
        check("f5_count", fv_count, 5);
        check("f5_digits", {16'h0, digits}, 32'h9865);
        check("f5_an_err", {31'h0, an_err}, 32'h0);
        check("f5_range", {31'h0, range_err}, {31'h0, RC});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
